// File: rtl/relu_vsq_buffer.sv
// relu_vsq_buffer
// Applies per-lane signed ReLU to incoming accumulator rows, forwards each
// ReLU'd row to the quantizer running-max input and collects DEPTH rows in
// a VSQ buffer. When the buffer fills, a one-cycle start pulse is issued and
// new input is held off while the quantizer computes scales and reads back.

module relu_vsq_buffer #(
   parameter int LANES     = 16,
   parameter int DW        = 40,
   parameter int DEPTH     = 64,
   parameter int AW        = 6,
   parameter int DRAIN_CYC = 66
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [LANES*DW-1:0]   i_acc_data,
   output logic [LANES*DW-1:0]   o_relu_data,
   output logic                  o_start,
   output logic [AW:0]           o_fill_cnt,
   input  logic [AW-1:0]         i_rd_addr,
   output logic [LANES*DW-1:0]   o_rd_data
);

   localparam int DCW = $clog2(DRAIN_CYC);

   typedef enum logic {S_FILL, S_DRAIN} state_t;

   state_t               state;
   state_t               state_next;
   logic [AW-1:0]        wr_ptr;
   logic [AW:0]          fill_cnt;
   logic [DCW-1:0]       drain_cnt;
   logic                 accept;
   logic                 last_row;
   logic                 drain_done;
   logic [LANES*DW-1:0]  relu_row;
   logic [LANES*DW-1:0]  vsq_mem [DEPTH];

   assign accept     = i_valid && o_ready;
   assign last_row   = (wr_ptr == AW'(DEPTH - 1));
   assign drain_done = (state == S_DRAIN) && (drain_cnt == DCW'(DRAIN_CYC - 1));
   assign o_fill_cnt = fill_cnt;
   assign o_rd_data  = vsq_mem[i_rd_addr];

   // Per-lane ReLU: a negative lane (MSB set) becomes zero, otherwise passes through
   always_comb begin
      relu_row = '0;
      for (int g = 0; g < LANES; g++) begin
         relu_row[g*DW +: DW] = i_acc_data[g*DW + DW - 1] ? {DW{1'b0}} : i_acc_data[g*DW +: DW];
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_FILL;
      end else begin
         state <= state_next;
      end
   end

   // Next state: go to drain on the row that fills the buffer, return after the drain window
   always_comb begin
      state_next = state;
      case (state)
         S_FILL:  if (accept && last_row) state_next = S_DRAIN;
         S_DRAIN: if (drain_done)         state_next = S_FILL;
         default: state_next = S_FILL;
      endcase
   end

   // Outputs decoded from state alone so ready never depends on valid
   always_comb begin
      o_ready = (state == S_FILL);
   end

   // Pointer, fill count, drain counter and the registered output row/start pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr      <= '0;
         fill_cnt    <= '0;
         drain_cnt   <= '0;
         o_start     <= 1'b0;
         o_relu_data <= '0;
      end else begin
         o_start     <= accept && last_row;
         o_relu_data <= accept ? relu_row : '0;
         if (accept) begin
            wr_ptr   <= wr_ptr + AW'(1);
            fill_cnt <= fill_cnt + (AW+1)'(1);
         end else if (drain_done) begin
            fill_cnt <= '0;
         end
         if (state == S_DRAIN && !drain_done) begin
            drain_cnt <= drain_cnt + DCW'(1);
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // Buffer storage is never reset; only accepted rows are written
   always_ff @(posedge i_clk) begin
      if (accept) begin
         vsq_mem[wr_ptr] <= relu_row;
      end
   end

endmodule

// File: tb/tb_relu_vsq_buffer.sv
// tb_relu_vsq_buffer
// Directed bench for relu_vsq_buffer: reset state, single-beat ReLU, full
// buffer with start pulse and drain window, gapped input, mid-fill reset.

module tb_relu_vsq_buffer;

   localparam int LANES     = 16;
   localparam int DW        = 40;
   localparam int DEPTH     = 64;
   localparam int AW        = 6;
   localparam int DRAIN_CYC = 66;
   localparam int RW        = LANES * DW;

   logic           i_clk;
   logic           i_rst_n;
   logic           i_valid;
   logic           o_ready;
   logic [RW-1:0]  i_acc_data;
   logic [RW-1:0]  o_relu_data;
   logic           o_start;
   logic [AW:0]    o_fill_cnt;
   logic [AW-1:0]  i_rd_addr;
   logic [RW-1:0]  o_rd_data;

   int testsRun;
   int testsFailed;

   relu_vsq_buffer #(
      .LANES(LANES), .DW(DW), .DEPTH(DEPTH), .AW(AW), .DRAIN_CYC(DRAIN_CYC)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .i_acc_data(i_acc_data),
      .o_relu_data(o_relu_data),
      .o_start(o_start),
      .o_fill_cnt(o_fill_cnt),
      .i_rd_addr(i_rd_addr),
      .o_rd_data(o_rd_data)
   );

   // Free-running clock, period 10
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Row pattern: lane g of row k = k*16+g+off; with neg set, lane 15 of odd rows is -(k+1)
   function automatic logic [RW-1:0] makeRow(input int k, input int off, input bit neg);
      logic [RW-1:0] r;
      r = '0;
      for (int g = 0; g < LANES; g++) begin
         if (neg && g == LANES - 1 && (k % 2) == 1) r[g*DW +: DW] = 40'(-(k + 1));
         else                                       r[g*DW +: DW] = 40'(k*16 + g + off);
      end
      return r;
   endfunction

   // Expected ReLU'd row for the same pattern: the negative lane reads as zero
   function automatic logic [RW-1:0] expRow(input int k, input int off, input bit neg);
      logic [RW-1:0] r;
      r = '0;
      for (int g = 0; g < LANES; g++) begin
         if (neg && g == LANES - 1 && (k % 2) == 1) r[g*DW +: DW] = 40'd0;
         else                                       r[g*DW +: DW] = 40'(k*16 + g + off);
      end
      return r;
   endfunction

   task automatic applyStimulus(input logic valid, input logic [RW-1:0] data);
      i_valid    = valid;
      i_acc_data = data;
   endtask

   task automatic stepCycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [RW-1:0] observed, input logic [RW-1:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [RW-1:0] vec;
      logic [RW-1:0] expv;
      logic [RW-1:0] fill999;

      testsRun    = 0;
      testsFailed = 0;
      i_rst_n     = 1'b0;
      i_valid     = 1'b0;
      i_acc_data  = '0;
      i_rd_addr   = '0;
      fill999     = '0;
      for (int g = 0; g < LANES; g++) fill999[g*DW +: DW] = 40'd999;

      // Reset then 10 idle cycles
      #12;
      i_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         stepCycle();
         checkOutput("idle_start", o_start, 0);
      end
      checkOutput("rst_ready", o_ready, 1);
      checkOutput("rst_relu", o_relu_data, 0);
      checkOutput("rst_fill", o_fill_cnt, 0);

      // Single beat: lane0 = -10, lane1 = 25
      vec = '0;
      vec[0 +: DW]  = 40'hFF_FFFF_FFF6;
      vec[DW +: DW] = 40'd25;
      expv = '0;
      expv[DW +: DW] = 40'd25;
      applyStimulus(1'b1, vec);
      stepCycle();
      checkOutput("single_relu", o_relu_data, expv);
      checkOutput("single_fill", o_fill_cnt, 1);
      applyStimulus(1'b0, '0);
      i_rd_addr = '0;
      #1;
      checkOutput("single_rd", o_rd_data, expv);
      stepCycle();
      checkOutput("single_relu_idle", o_relu_data, 0);

      // Fresh start for the full-buffer test
      i_rst_n = 1'b0;
      #2;
      i_rst_n = 1'b1;
      checkOutput("rst2_fill", o_fill_cnt, 0);

      // 64 back-to-back beats
      for (int k = 0; k < DEPTH; k++) begin
         applyStimulus(1'b1, makeRow(k, 0, 1'b0));
         stepCycle();
         checkOutput("full_relu", o_relu_data, expRow(k, 0, 1'b0));
         checkOutput("full_start", o_start, (k == DEPTH - 1) ? 1 : 0);
         checkOutput("full_fill", o_fill_cnt, k + 1);
      end
      checkOutput("drain_ready_t1", o_ready, 0);

      // Hold valid high with 999 throughout the drain window (T+2 .. T+66)
      applyStimulus(1'b1, fill999);
      for (int d = 2; d <= DRAIN_CYC; d++) begin
         stepCycle();
         checkOutput("drain_ready", o_ready, 0);
         checkOutput("drain_relu", o_relu_data, 0);
         checkOutput("drain_start", o_start, 0);
      end
      checkOutput("drain_fill_end", o_fill_cnt, DEPTH);
      stepCycle();
      applyStimulus(1'b0, '0);
      checkOutput("drain_ready_t67", o_ready, 1);
      checkOutput("drain_fill_clear", o_fill_cnt, 0);

      // Read sweep: every row intact, nothing written during the drain
      for (int k = 0; k < DEPTH; k++) begin
         i_rd_addr = AW'(k);
         stepCycle();
         checkOutput("sweep_rd", o_rd_data, expRow(k, 0, 1'b0));
      end

      // Gapped input: one beat every third cycle, odd rows carry a negative lane
      for (int k = 0; k < DEPTH; k++) begin
         applyStimulus(1'b1, makeRow(k, 2000, 1'b1));
         stepCycle();
         checkOutput("gap_relu", o_relu_data, expRow(k, 2000, 1'b1));
         checkOutput("gap_start", o_start, (k == DEPTH - 1) ? 1 : 0);
         applyStimulus(1'b0, '0);
         stepCycle();
         checkOutput("gap_relu_idle1", o_relu_data, 0);
         checkOutput("gap_start_idle1", o_start, 0);
         stepCycle();
         checkOutput("gap_relu_idle2", o_relu_data, 0);
      end
      for (int i = 0; i < DRAIN_CYC - 2; i++) stepCycle();
      checkOutput("gap_ready_after", o_ready, 1);
      i_rd_addr = AW'(5);
      #1;
      checkOutput("gap_rd5", o_rd_data, expRow(5, 2000, 1'b1));

      // 30 beats then asynchronous reset mid-cycle
      for (int k = 0; k < 30; k++) begin
         applyStimulus(1'b1, makeRow(k, 5000, 1'b0));
         stepCycle();
      end
      applyStimulus(1'b0, '0);
      checkOutput("pre_rst_relu", o_relu_data, expRow(29, 5000, 1'b0));
      i_rst_n = 1'b0;
      #2;
      checkOutput("async_ready", o_ready, 1);
      checkOutput("async_start", o_start, 0);
      checkOutput("async_relu", o_relu_data, 0);
      checkOutput("async_fill", o_fill_cnt, 0);
      i_rst_n = 1'b1;

      // After reset, a fresh 64 beats are needed for start
      for (int k = 0; k < DEPTH; k++) begin
         applyStimulus(1'b1, makeRow(k, 7000, 1'b0));
         stepCycle();
         checkOutput("post_rst_start", o_start, (k == DEPTH - 1) ? 1 : 0);
         if (k == 33) checkOutput("post_rst_fill34", o_fill_cnt, 34);
      end
      applyStimulus(1'b0, '0);
      checkOutput("post_rst_fill", o_fill_cnt, DEPTH);
      for (int i = 0; i < DRAIN_CYC; i++) stepCycle();
      checkOutput("post_rst_ready", o_ready, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
